// File: rtl/acq_search_ctrl.sv
// acq_search_ctrl: steps the coherent integrator through NUM_PHASES code-phase
// hypotheses, tracks the peak energy and its phase, and reports found/not-found.
// Latency: 499 cycles per hypothesis (SHIFT + 497 DWELL + EVAL), done at 499*NUM_PHASES+1.
// Backpressure: none; waits on result_ok_in per dwell and aborts on a dwell timeout.

module acq_search_ctrl #(
  parameter int NUM_PHASES    = 1023,
  parameter int PHASE_W       = 10,
  parameter int ENERGY_W      = 20,
  parameter int DWELL_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ENERGY_W-1:0] threshold,
  input  logic [ENERGY_W-1:0] energy_in,
  input  logic                result_ok_in,
  output logic                shift_parse,
  output logic [PHASE_W-1:0]  phase_idx,
  output logic                busy,
  output logic                done,
  output logic                acq_found,
  output logic [PHASE_W-1:0]  best_phase,
  output logic [ENERGY_W-1:0] best_energy,
  output logic                timeout_err
);

  // Timer is wide enough to hold DWELL_TIMEOUT itself.
  localparam int TW = $clog2(DWELL_TIMEOUT + 1);

  // Last hypothesis index; phase_idx stops here and never wraps.
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  // Timer value on the final permitted DWELL cycle.
  localparam logic [TW-1:0] TIMER_LAST = TW'(DWELL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    DWELL = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [TW-1:0]       dwell_timer;
  logic [ENERGY_W-1:0] energy_hold;
  logic [ENERGY_W-1:0] thr_latched;

  // Peak candidate seen by EVAL: the captured energy wins only if strictly
  // greater, so the earliest phase keeps the peak on ties.
  logic                new_peak;
  logic [ENERGY_W-1:0] peak_after_eval;

  // Peak comparison against the stored best, evaluated every cycle but only
  // consumed in EVAL.
  always_comb begin
    new_peak        = (energy_hold > best_energy);
    peak_after_eval = new_peak ? energy_hold : best_energy;
  end

  // Search FSM; all outputs are registered alongside the state so they
  // change together with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dwell_timer <= '0;
      energy_hold <= '0;
      thr_latched <= '0;
      shift_parse <= 1'b0;
      phase_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      acq_found   <= 1'b0;
      best_phase  <= '0;
      best_energy <= '0;
      timeout_err <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      // Cancel: keep partial best_* for inspection, but never report a find.
      state       <= IDLE;
      shift_parse <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      acq_found   <= 1'b0;
    end else begin
      // Pulse outputs default low; the branches below raise them for one cycle.
      shift_parse <= 1'b0;
      done        <= 1'b0;

      case (state)
        IDLE: begin
          // abort in IDLE only blocks a coincident start.
          if (start && !abort) begin
            state       <= SHIFT;
            shift_parse <= 1'b1;
            busy        <= 1'b1;
            phase_idx   <= '0;
            best_phase  <= '0;
            best_energy <= '0;
            acq_found   <= 1'b0;
            timeout_err <= 1'b0;
            thr_latched <= threshold;
          end
        end

        SHIFT: begin
          // Integrator restarts at the end of this cycle; start a fresh dwell.
          dwell_timer <= '0;
          state       <= DWELL;
        end

        DWELL: begin
          if (result_ok_in) begin
            energy_hold <= energy_in;
            state       <= EVAL;
          end else if (dwell_timer == TIMER_LAST) begin
            // Integrator never answered: give up on the whole search.
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            dwell_timer <= dwell_timer + 1'b1;
          end
        end

        EVAL: begin
          if (new_peak) begin
            best_energy <= energy_hold;
            best_phase  <= phase_idx;
          end
          if (phase_idx == LAST_PHASE) begin
            // Decision uses the peak including this final hypothesis, so it
            // is valid in the same cycle as done.
            acq_found <= (peak_after_eval >= thr_latched);
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            phase_idx   <= phase_idx + 1'b1;
            shift_parse <= 1'b1;
            state       <= SHIFT;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_search_ctrl.sv
// tb_acq_search_ctrl: directed checks of acq_search_ctrl with NUM_PHASES=4,
// using a cycle-accurate integrator model (result 497 cycles after shift_parse).
// Cycle numbers are relative to the cycle in which start is sampled (cycle 0).

module tb_acq_search_ctrl;

  localparam int NP = 4;
  localparam int PW = 10;
  localparam int EW = 20;
  localparam int TO = 1023;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [EW-1:0] threshold;
  logic [EW-1:0] energy_in;
  logic          result_ok_in;
  logic          shift_parse;
  logic [PW-1:0] phase_idx;
  logic          busy;
  logic          done;
  logic          acq_found;
  logic [PW-1:0] best_phase;
  logic [EW-1:0] best_energy;
  logic          timeout_err;

  acq_search_ctrl #(
    .NUM_PHASES   (NP),
    .PHASE_W      (PW),
    .ENERGY_W     (EW),
    .DWELL_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .threshold   (threshold),
    .energy_in   (energy_in),
    .result_ok_in(result_ok_in),
    .shift_parse (shift_parse),
    .phase_idx   (phase_idx),
    .busy        (busy),
    .done        (done),
    .acq_found   (acq_found),
    .best_phase  (best_phase),
    .best_energy (best_energy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter, monitor and integrator model.
  int        tcyc = 0;
  logic      mon_clr;
  int        shift_n;
  int        shift_cyc [0:7];
  int        done_n;
  int        done_cyc;
  logic      int_run;
  int        int_cnt;
  int        int_ph;
  int        stall_ph;
  logic [EW-1:0] etab [0:3];

  assign result_ok_in = int_run && (int_cnt == 496) && (int_ph != stall_ph);
  assign energy_in    = etab[int_ph[1:0]];

  // Record shift_parse/done pulses and model the integrator dwell counter.
  always @(posedge clk) begin
    tcyc <= tcyc + 1;
    if (mon_clr) begin
      shift_n <= 0;
      done_n  <= 0;
      int_run <= 1'b0;
      int_cnt <= 0;
      int_ph  <= 0;
    end else begin
      if (shift_parse) begin
        if (shift_n < 8) shift_cyc[shift_n] <= tcyc;
        shift_n <= shift_n + 1;
        int_ph  <= shift_n;
        int_run <= 1'b1;
        int_cnt <= 0;
      end else if (result_ok_in) begin
        int_run <= 1'b0;
      end else if (int_run) begin
        int_cnt <= int_cnt + 1;
      end
      if (done) begin
        done_n   <= done_n + 1;
        done_cyc <= tcyc;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int c0     = 0;
  int saved_shift_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Clear the monitor, then present start for one cycle; that cycle is cycle 0.
  task automatic launch(input logic [EW-1:0] thr);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr   = 1'b0;
    threshold = thr;
    start     = 1'b1;
    c0        = tcyc;
    @(negedge clk);
    start     = 1'b0;
    threshold = '0;   // controller must use the latched value
  endtask

  task automatic wait_rel(input int r);
    while ((tcyc - c0) < r) @(negedge clk);
  endtask

  task automatic set_etab(input int e0, input int e1, input int e2, input int e3);
    etab[0] = EW'(e0);
    etab[1] = EW'(e1);
    etab[2] = EW'(e2);
    etab[3] = EW'(e3);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    threshold = '0;
    mon_clr   = 1'b1;
    stall_ph  = -1;
    set_etab(0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_shift", shift_parse, 0);
    chk("rst_done", done, 0);
    chk("rst_phase", phase_idx, 0);
    chk("rst_best_phase", best_phase, 0);
    chk("rst_best_energy", best_energy, 0);
    chk("rst_acq", acq_found, 0);
    chk("rst_tmo", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic search: 100, 900, 300, 50 against threshold 500
    set_etab(100, 900, 300, 50);
    launch(500);
    wait_rel(700);
    chk("basic_phase_mid", phase_idx, 1);
    chk("basic_busy_mid", busy, 1);
    wait_rel(1997);
    chk("basic_done_pulse", done, 1);
    wait_rel(2000);
    chk("basic_shift_n", shift_n, 4);
    for (int i = 0; i < NP; i++)
      chk($sformatf("basic_shift%0d_cyc", i), shift_cyc[i] - c0, 1 + 499 * i);
    chk("basic_done_cyc", done_cyc - c0, 1997);
    chk("basic_done_n", done_n, 1);
    chk("basic_best_phase", best_phase, 1);
    chk("basic_best_energy", best_energy, 900);
    chk("basic_acq", acq_found, 1);
    chk("basic_busy_end", busy, 0);
    chk("basic_phase_end", phase_idx, 3);

    // Tie and miss, with a start collision while busy
    set_etab(700, 700, 10, 10);
    launch(800);
    wait_rel(600);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(2005);
    chk("tie_shift_n", shift_n, 4);
    chk("tie_shift3_cyc", shift_cyc[3] - c0, 1498);
    chk("tie_done_cyc", done_cyc - c0, 1997);
    chk("tie_done_n", done_n, 1);
    chk("tie_best_phase", best_phase, 0);
    chk("tie_best_energy", best_energy, 700);
    chk("tie_acq", acq_found, 0);

    // Timeout: integrator never answers in phase 2
    set_etab(5, 6, 7, 8);
    stall_ph = 2;
    launch(1);
    chk("tmo_cleared_acq", acq_found, 0);
    wait_rel(2022);
    chk("tmo_busy_last_dwell", busy, 1);
    chk("tmo_err_before", timeout_err, 0);
    wait_rel(2023);
    chk("tmo_busy_after", busy, 0);
    chk("tmo_err_after", timeout_err, 1);
    wait_rel(2600);
    chk("tmo_done_n", done_n, 0);
    chk("tmo_shift_n", shift_n, 3);
    chk("tmo_best_phase", best_phase, 1);
    chk("tmo_best_energy", best_energy, 6);
    chk("tmo_acq", acq_found, 0);
    chk("tmo_err_sticky", timeout_err, 1);
    stall_ph = -1;

    // Abort mid-dwell of phase 1, then a clean search
    set_etab(100, 900, 300, 50);
    launch(500);
    chk("abort_tmo_cleared", timeout_err, 0);
    wait_rel(700);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_acq", acq_found, 0);
    chk("abort_best_phase", best_phase, 0);
    chk("abort_best_energy", best_energy, 100);
    wait_rel(1400);
    chk("abort_shift_n", shift_n, 2);
    chk("abort_done_n", done_n, 0);
    launch(500);
    wait_rel(2005);
    chk("clean_done_cyc", done_cyc - c0, 1997);
    chk("clean_done_n", done_n, 1);
    chk("clean_best_phase", best_phase, 1);
    chk("clean_best_energy", best_energy, 900);
    chk("clean_acq", acq_found, 1);

    // start and abort together in IDLE: search must not start
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    start   = 1'b1;
    abort   = 1'b1;
    threshold = 20'd1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("collide_busy", busy, 0);
    chk("collide_shift_n", shift_n, 0);

    // Reset mid-dwell of phase 3
    launch(500);
    wait_rel(1700);
    chk("prerst_shift_n", shift_n, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_shift", shift_parse, 0);
    chk("midrst_done", done, 0);
    chk("midrst_phase", phase_idx, 0);
    chk("midrst_best_phase", best_phase, 0);
    chk("midrst_best_energy", best_energy, 0);
    chk("midrst_acq", acq_found, 0);
    chk("midrst_tmo", timeout_err, 0);
    saved_shift_n = shift_n;
    repeat (600) @(negedge clk);
    chk("postrst_shift_n", shift_n, saved_shift_n);
    chk("postrst_done_n", done_n, 0);
    chk("postrst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
